// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared constants and state encoding for the program RAM loader
package ram_pkg;
    localparam int RAM_ADDR_W = 4;
    localparam int RAM_DATA_W = 8;
    localparam int RAM_DEPTH  = 2 ** RAM_ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CHK,
        VERIFY
    } state_t;
endpackage

// File: rtl/ram_checksum_acc.sv
// rtl/ram_checksum_acc.sv - clear/enable modular byte accumulator
module ram_checksum_acc #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] sum
);
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (en) begin
            sum <= sum + din;
        end
    end
endmodule

// File: rtl/ram_loader.sv
// rtl/ram_loader.sv - loads a byte stream into program RAM, then reads it back and checks a modular checksum
module ram_loader
    import ram_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              Start,
    input  logic [DATA_W-1:0] In_Data,
    input  logic              In_Valid,
    output logic              In_Ready,
    output logic [ADDR_W-1:0] Ram_Addr,
    output logic              Ram_Wr_En,
    output logic [DATA_W-1:0] Ram_Wr_Data,
    output logic              Ram_Rd_En,
    input  logic [DATA_W-1:0] Ram_Rd_Data,
    output logic              Busy,
    output logic              Done,
    output logic              Error
);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_inc;
    logic [DATA_W-1:0] ck, sum_in, sum_rd, sum_rd_nxt;
    logic              hs, last_cnt, start_ok;

    assign In_Ready   = (state == LOAD) || (state == CHK);
    assign hs         = In_Valid && In_Ready;
    assign last_cnt   = (cnt == LAST);
    assign cnt_inc    = cnt + 1'b1;
    assign start_ok   = (state == IDLE) && Start;
    // Final read byte is still on the bus at the decision edge, so fold it in here.
    assign sum_rd_nxt = sum_rd + Ram_Rd_Data;

    ram_checksum_acc #(.W(DATA_W)) u_sum_in (
        .CLK   (CLK),
        .RST_N (RST_N),
        .clr   (start_ok),
        .en    ((state == LOAD) && hs),
        .din   (In_Data),
        .sum   (sum_in)
    );

    ram_checksum_acc #(.W(DATA_W)) u_sum_rd (
        .CLK   (CLK),
        .RST_N (RST_N),
        .clr   (start_ok),
        .en    (state == VERIFY),
        .din   (Ram_Rd_Data),
        .sum   (sum_rd)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start)           state_nxt = LOAD;
            LOAD:    if (hs && last_cnt)  state_nxt = CHK;
            CHK:     if (hs)              state_nxt = VERIFY;
            VERIFY:  if (last_cnt)        state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt         <= '0;
            ck          <= '0;
            Ram_Addr    <= '0;
            Ram_Wr_En   <= 1'b0;
            Ram_Wr_Data <= '0;
            Ram_Rd_En   <= 1'b0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            Error       <= 1'b0;
        end else begin
            Ram_Wr_En <= 1'b0;
            Done      <= 1'b0;
            Busy      <= (state_nxt != IDLE);
            case (state)
                IDLE: begin
                    if (Start) begin
                        cnt   <= '0;
                        Error <= 1'b0;
                    end
                end
                LOAD: begin
                    if (hs) begin
                        Ram_Addr    <= cnt[ADDR_W-1:0];
                        Ram_Wr_Data <= In_Data;
                        Ram_Wr_En   <= 1'b1;
                        cnt         <= cnt_inc;
                    end
                end
                CHK: begin
                    if (hs) begin
                        ck        <= In_Data;
                        cnt       <= '0;
                        Ram_Addr  <= '0;
                        Ram_Rd_En <= 1'b1;
                    end
                end
                VERIFY: begin
                    if (last_cnt) begin
                        cnt       <= '0;
                        Ram_Addr  <= '0;
                        Ram_Rd_En <= 1'b0;
                        if ((sum_rd_nxt == ck) && (sum_in == ck)) begin
                            Done <= 1'b1;
                        end else begin
                            Error <= 1'b1;
                        end
                    end else begin
                        cnt      <= cnt_inc;
                        Ram_Addr <= cnt_inc[ADDR_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_loader.sv
// tb/tb_ram_loader.sv - scoreboard bench for ram_loader with a behavioural 16x8 RAM
module tb_ram_loader;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int N  = 16;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          Start = 1'b0;
    logic [DW-1:0] In_Data = '0;
    logic          In_Valid = 1'b0;
    logic          In_Ready;
    logic [AW-1:0] Ram_Addr;
    logic          Ram_Wr_En;
    logic [DW-1:0] Ram_Wr_Data;
    logic          Ram_Rd_En;
    logic [DW-1:0] Ram_Rd_Data;
    logic          Busy, Done, Error;

    ram_loader dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .Start       (Start),
        .In_Data     (In_Data),
        .In_Valid    (In_Valid),
        .In_Ready    (In_Ready),
        .Ram_Addr    (Ram_Addr),
        .Ram_Wr_En   (Ram_Wr_En),
        .Ram_Wr_Data (Ram_Wr_Data),
        .Ram_Rd_En   (Ram_Rd_En),
        .Ram_Rd_Data (Ram_Rd_Data),
        .Busy        (Busy),
        .Done        (Done),
        .Error       (Error)
    );

    always #5 CLK = ~CLK;

    logic [DW-1:0] mem [N];
    bit            corrupt = 1'b0;
    int            cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;
    always @(posedge CLK) if (Ram_Wr_En) mem[Ram_Addr] <= Ram_Wr_Data;
    assign Ram_Rd_Data = (corrupt && Ram_Addr == 4'd5) ? (mem[Ram_Addr] & 8'hFE) : mem[Ram_Addr];

    typedef struct { int cyc; logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
    typedef struct { int cyc; logic [AW-1:0] addr; } rd_t;
    typedef struct { int cyc; bit done; bit err; } out_t;

    wr_t  wr_q[$];
    rd_t  rd_q[$];
    out_t out_q[$];
    int   checks = 0;
    int   failures = 0;
    int   exp_addr = 0;
    logic busy_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: actual=event required=no_event", name);
    endtask

    // Monitor: pops expected writes/reads/outcomes whenever the DUT presents them
    always @(negedge CLK) begin
        wr_t  w;
        rd_t  r;
        out_t o;
        if (Ram_Wr_En || Ram_Rd_En) check("wr_rd_exclusive", 32'(Ram_Wr_En & Ram_Rd_En), 32'd0);
        if (Ram_Wr_En) begin
            if (wr_q.size() == 0) fail("unexpected_write");
            else begin
                w = wr_q.pop_front();
                check("wr_cycle", 32'(cyc), 32'(w.cyc));
                check("wr_addr", 32'(Ram_Addr), 32'(w.addr));
                check("wr_data", 32'(Ram_Wr_Data), 32'(w.data));
            end
        end
        if (Ram_Rd_En) begin
            if (rd_q.size() == 0) fail("unexpected_read");
            else begin
                r = rd_q.pop_front();
                check("rd_cycle", 32'(cyc), 32'(r.cyc));
                check("rd_addr", 32'(Ram_Addr), 32'(r.addr));
            end
        end
        if (Done && !busy_prev) fail("done_without_busy_fall");
        if (busy_prev && !Busy) begin
            if (out_q.size() == 0) fail("unexpected_session_end");
            else begin
                o = out_q.pop_front();
                if (o.cyc >= 0) check("end_cycle", 32'(cyc), 32'(o.cyc));
                check("end_done", 32'(Done), 32'(o.done));
                check("end_error", 32'(Error), 32'(o.err));
            end
        end
        busy_prev = Busy;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_start();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("busy_after_start", 32'(Busy), 32'd1);
        check("error_cleared_by_start", 32'(Error), 32'd0);
    endtask

    task automatic send_byte(input logic [DW-1:0] d, input int gap, input bit is_data, output int hs_cyc);
        int  n = 0;
        wr_t w;
        repeat (gap) begin
            In_Valid = 1'b0;
            tick();
        end
        In_Valid = 1'b1;
        In_Data  = d;
        while (!In_Ready && n < 50) begin
            tick();
            n++;
        end
        hs_cyc = cyc + 1;
        if (!In_Ready) begin
            fail("handshake_timeout");
            hs_cyc = -1;
            return;
        end
        if (is_data) begin
            w.cyc  = hs_cyc;
            w.addr = AW'(exp_addr);
            w.data = d;
            wr_q.push_back(w);
            exp_addr++;
        end
        tick();
    endtask

    task automatic session(input logic [DW-1:0] base, input int gap, input logic [DW-1:0] ck,
                           input bit exp_ok, input bit glitch);
        int   hc;
        int   n = 0;
        rd_t  r;
        out_t o;
        exp_addr = 0;
        do_start();
        for (int i = 0; i < N; i++) begin
            if (glitch && i == 3) Start = 1'b1;
            send_byte(base + DW'(i), gap, 1'b1, hc);
            Start = 1'b0;
        end
        send_byte(ck, gap, 1'b0, hc);
        In_Valid = 1'b0;
        if (hc >= 0) begin
            for (int i = 0; i < N; i++) begin
                r.cyc  = hc + i;
                r.addr = AW'(i);
                rd_q.push_back(r);
            end
            o.cyc  = hc + N;
            o.done = exp_ok;
            o.err  = !exp_ok;
            out_q.push_back(o);
        end
        if (glitch) begin
            repeat (5) tick();
            Start = 1'b1;
            tick();
            Start = 1'b0;
        end
        while (out_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        if (out_q.size() != 0) begin
            fail("session_timeout");
            out_q.delete();
            rd_q.delete();
            wr_q.delete();
        end
        tick();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_outputs"},
              32'({In_Ready, Ram_Addr, Ram_Wr_En, Ram_Wr_Data, Ram_Rd_En, Busy, Done, Error}), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   hc;
        out_t o;
        for (int i = 0; i < N; i++) mem[i] = '0;
        #12;
        check_outputs_zero("reset");
        RST_N = 1'b1;
        tick();
        check_outputs_zero("idle");

        // In_Valid in IDLE must not be consumed
        In_Valid = 1'b1;
        In_Data  = 8'h55;
        repeat (3) tick();
        check("idle_ready", 32'(In_Ready), 32'd0);
        In_Valid = 1'b0;

        session(8'h00, 0, 8'h78, 1'b1, 1'b0);
        session(8'h00, 1, 8'h78, 1'b1, 1'b0);
        session(8'h00, 0, 8'h77, 1'b0, 1'b0);
        repeat (3) tick();
        check("error_sticky", 32'(Error), 32'd1);
        corrupt = 1'b1;
        session(8'h00, 0, 8'h78, 1'b0, 1'b0);
        corrupt = 1'b0;
        session(8'h00, 0, 8'h78, 1'b1, 1'b1);

        // Abort mid-load with an asynchronous reset
        exp_addr = 0;
        do_start();
        for (int i = 0; i < 7; i++) send_byte(8'hA0 + DW'(i), 0, 1'b1, hc);
        In_Valid = 1'b0;
        tick();
        o.cyc  = -1;
        o.done = 1'b0;
        o.err  = 1'b0;
        out_q.push_back(o);
        #2 RST_N = 1'b0;
        #1 check_outputs_zero("async_reset");
        @(negedge CLK);
        #1;
        check("reset_end_seen", 32'(out_q.size()), 32'd0);
        for (int i = 0; i < 7; i++) check("partial_load", 32'(mem[i]), 32'(8'hA0 + DW'(i)));
        check("untouched_addr7", 32'(mem[7]), 32'h07);
        RST_N = 1'b1;
        tick();
        session(8'h00, 0, 8'h78, 1'b1, 1'b0);
        check("queues_drained", 32'(wr_q.size() + rd_q.size() + out_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
